// File: rtl/sram_port0_req_adapter.sv
// Port-0 request front-end for the interleaved SRAM macro array.
// Turns a valid/ready read/masked-write stream into the active-low csb0/web0 pin
// protocol, tracks the fixed read latency, and returns read data through a
// credit-protected response FIFO so response backpressure never loses data.
module sram_port0_req_adapter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_ADDRESSES  = 1024,
  parameter int READ_LATENCY   = 2,
  parameter int RSP_FIFO_DEPTH = 4,
  localparam int AW = $clog2(NUM_ADDRESSES),
  localparam int MW = DATA_WIDTH / 8,
  localparam int CW = $clog2(RSP_FIFO_DEPTH + 1)
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [AW-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MW-1:0]         req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [MW-1:0]         mem_wmask0,
  output logic [AW-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout,
  output logic [CW-1:0]         rd_outstanding
);

  localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  // latency pipe: one bit per read still travelling through the array
  logic [READ_LATENCY-1:0] r_pipe;
  logic [READ_LATENCY:0]   w_pipe_ext;
  // response FIFO state; storage is deliberately not reset
  logic [CW-1:0]           r_count;
  logic [PW-1:0]           r_wptr;
  logic [PW-1:0]           r_rptr;
  logic [DATA_WIDTH-1:0]   r_mem [RSP_FIFO_DEPTH];

  logic                    w_fire;
  logic                    w_rd_fire;
  logic                    w_push;
  logic                    w_pop;
  logic [CW:0]             w_inflight;
  logic [CW:0]             w_credits;
  logic                    w_has_credit;

  // credits come only from registered state, so rsp_ready never reaches req_ready
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      w_inflight = w_inflight + {{CW{1'b0}}, r_pipe[i]};
  end

  assign w_credits      = w_inflight + {1'b0, r_count};
  assign w_has_credit   = (w_credits < (CW+1)'(RSP_FIFO_DEPTH));
  assign rd_outstanding = w_credits[CW-1:0];

  // writes never consume credit; nothing is accepted while reset is held
  assign req_ready = rst_n & (req_we | w_has_credit);
  assign w_fire    = req_valid & req_ready;
  assign w_rd_fire = w_fire & ~req_we;

  // the array registers these on the same edge that accepts the request
  assign mem_csb0    = ~w_fire;
  assign mem_web0    = ~(w_fire & req_we);
  assign mem_address = req_addr;
  assign mem_datain  = req_wdata;
  assign mem_wmask0  = req_wmask;

  // the bit leaving the pipe marks the edge where mem_dataout is valid
  assign w_pipe_ext = {r_pipe, w_rd_fire};
  assign w_push     = r_pipe[READ_LATENCY-1];
  assign w_pop      = rsp_valid & rsp_ready;
  assign rsp_valid  = (r_count != '0);
  assign rsp_rdata  = r_mem[r_rptr];

  // shift acceptance of each read towards its data-return edge
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) r_pipe <= '0;
    else        r_pipe <= w_pipe_ext[READ_LATENCY-1:0];
  end

  // FIFO pointers and occupancy; pointers wrap at the depth, not a power of two
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= (r_wptr == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= (r_rptr == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // capture returning array data into the FIFO slot at the write pointer
  always_ff @(posedge clk0) begin
    if (w_push) r_mem[r_wptr] <= mem_dataout;
  end

  // credit accounting guarantees a free slot for every returning read
  a_no_overflow: assert property (@(posedge clk0) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == CW'(RSP_FIFO_DEPTH))));

endmodule
